// File: rtl/ibuffer_warp_queues_if.sv
`default_nettype none
// ============================================================================
// ibuffer_warp_queues_if : grant / I-cache return / dispatch bundle for the
// per-warp instruction buffer. Err_IBuffer exists only with IBUF_ERR_CHECK_EN.
// Revision 1.0
// ============================================================================
interface ibuffer_warp_queues_if #(
  parameter int IW = 32
);
  logic [7:0]    GRT;
  logic          Valid_ICache_1;
  logic [2:0]    WarpID_ICache_1;
  logic [IW-1:0] Instr_ICache_1;
  logic          Valid_ICache_2;
  logic [2:0]    WarpID_ICache_2;
  logic [IW-1:0] Instr_ICache_2;
  logic          Pop_Valid;
  logic [2:0]    Pop_WarpID;
  logic [7:0]    Flush_Warp;
  logic [2:0]    Rd_WarpID;
  logic [7:0]    REQ_IBuffer_PC;
  logic [7:0]    Stall_IBuffer_PC;
  logic [7:0]    Head_Valid;
  logic [IW-1:0] Rd_Instr;
`ifdef IBUF_ERR_CHECK_EN
  logic          Err_IBuffer;

  modport master (
    output GRT, Valid_ICache_1, WarpID_ICache_1, Instr_ICache_1,
           Valid_ICache_2, WarpID_ICache_2, Instr_ICache_2,
           Pop_Valid, Pop_WarpID, Flush_Warp, Rd_WarpID,
    input  REQ_IBuffer_PC, Stall_IBuffer_PC, Head_Valid, Rd_Instr, Err_IBuffer
  );
  modport slave (
    input  GRT, Valid_ICache_1, WarpID_ICache_1, Instr_ICache_1,
           Valid_ICache_2, WarpID_ICache_2, Instr_ICache_2,
           Pop_Valid, Pop_WarpID, Flush_Warp, Rd_WarpID,
    output REQ_IBuffer_PC, Stall_IBuffer_PC, Head_Valid, Rd_Instr, Err_IBuffer
  );
`else
  modport master (
    output GRT, Valid_ICache_1, WarpID_ICache_1, Instr_ICache_1,
           Valid_ICache_2, WarpID_ICache_2, Instr_ICache_2,
           Pop_Valid, Pop_WarpID, Flush_Warp, Rd_WarpID,
    input  REQ_IBuffer_PC, Stall_IBuffer_PC, Head_Valid, Rd_Instr
  );
  modport slave (
    input  GRT, Valid_ICache_1, WarpID_ICache_1, Instr_ICache_1,
           Valid_ICache_2, WarpID_ICache_2, Instr_ICache_2,
           Pop_Valid, Pop_WarpID, Flush_Warp, Rd_WarpID,
    output REQ_IBuffer_PC, Stall_IBuffer_PC, Head_Valid, Rd_Instr
  );
`endif
endinterface
`default_nettype wire

// File: rtl/ibuffer_warp_queues.sv
`default_nettype none
// ============================================================================
// ibuffer_warp_queues : per-warp instruction FIFOs with fetch-slot reservation
// and stale-return dropping after flush. Optional macro: IBUF_ERR_CHECK_EN.
// Revision 1.0
// ============================================================================
module ibuffer_warp_queues #(
  parameter int NUM_WARPS = 8,
  parameter int DEPTH     = 2,
  parameter int IW        = 32
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  ibuffer_warp_queues_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] rd_q   [NUM_WARPS];
  logic [PTR_W-1:0] rd_d   [NUM_WARPS];
  logic [PTR_W-1:0] wr_q   [NUM_WARPS];
  logic [PTR_W-1:0] wr_d   [NUM_WARPS];
  logic [CNT_W-1:0] occ_q  [NUM_WARPS];
  logic [CNT_W-1:0] occ_d  [NUM_WARPS];
  logic [CNT_W-1:0] inf_q  [NUM_WARPS];
  logic [CNT_W-1:0] inf_d  [NUM_WARPS];
  logic [CNT_W-1:0] drop_q [NUM_WARPS];
  logic [CNT_W-1:0] drop_d [NUM_WARPS];
  logic [IW-1:0]    mem_q  [NUM_WARPS][DEPTH];
  logic [IW-1:0]    mem_d  [NUM_WARPS][DEPTH];

  logic [CNT_W:0]   fill   [NUM_WARPS];
  logic [7:0]       req_vec;
  logic [7:0]       stall_vec;
  logic [7:0]       hv_vec;

  logic             ret_v     [2];
  logic [2:0]       ret_id    [2];
  logic [IW-1:0]    ret_instr [2];

`ifdef IBUF_ERR_CHECK_EN
  logic             err_q;
  logic             err_d;
  logic             err_hit;
`endif

  // Status vectors come only from flops so the resolver sees no input-to-output path.
  always_comb begin
    req_vec   = '0;
    stall_vec = '0;
    hv_vec    = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      fill[w]      = {1'b0, occ_q[w]} + {1'b0, inf_q[w]};
      req_vec[w]   = fill[w] < DEPTH_X;
      stall_vec[w] = fill[w] == DEPTH_X;
      hv_vec[w]    = occ_q[w] != '0;
    end
  end

  always_comb begin
    ret_v[0]     = bus.Valid_ICache_1;
    ret_id[0]    = bus.WarpID_ICache_1;
    ret_instr[0] = bus.Instr_ICache_1;
    ret_v[1]     = bus.Valid_ICache_2;
    ret_id[1]    = bus.WarpID_ICache_2;
    ret_instr[1] = bus.Instr_ICache_2;
  end

  always_comb begin
    logic [CNT_W-1:0] occ_v;
    logic [CNT_W-1:0] inf_v;
    logic [CNT_W-1:0] drop_v;
    logic [PTR_W-1:0] wr_v;
    occ_v  = '0;
    inf_v  = '0;
    drop_v = '0;
    wr_v   = '0;
    mem_d  = mem_q;
`ifdef IBUF_ERR_CHECK_EN
    err_hit = $countones(bus.GRT) > 2;
`endif
    for (int w = 0; w < NUM_WARPS; w++) begin
      rd_d[w] = rd_q[w];
      occ_v   = occ_q[w];
      inf_v   = inf_q[w];
      drop_v  = drop_q[w];
      wr_v    = wr_q[w];
      // Port 1 is resolved before port 2 so same-warp pairs land in order.
      for (int p = 0; p < 2; p++) begin
        if (ret_v[p] && (ret_id[p] == 3'(w))) begin
          if (drop_v != '0) begin
            drop_v = drop_v - CNT_ONE;
            inf_v  = inf_v - CNT_ONE;
          end else if (inf_v != '0) begin
            inf_v = inf_v - CNT_ONE;
            if (!bus.Flush_Warp[w]) begin
              mem_d[w][wr_v] = ret_instr[p];
              wr_v           = wr_v + PTR_ONE;
              occ_v          = occ_v + CNT_ONE;
            end
          end else begin
`ifdef IBUF_ERR_CHECK_EN
            err_hit = 1'b1;
`endif
          end
        end
      end
      if (bus.GRT[w]) begin
        if (req_vec[w]) begin
          inf_v = inf_v + CNT_ONE;
        end else begin
`ifdef IBUF_ERR_CHECK_EN
          err_hit = 1'b1;
`endif
        end
      end
      // Flush keeps the reservations but marks every one of them stale.
      if (bus.Flush_Warp[w]) begin
        occ_v   = '0;
        rd_d[w] = wr_q[w];
        wr_v    = wr_q[w];
        drop_v  = inf_v;
      end else if (bus.Pop_Valid && (bus.Pop_WarpID == 3'(w)) && (occ_q[w] != '0)) begin
        rd_d[w] = rd_q[w] + PTR_ONE;
        occ_v   = occ_v - CNT_ONE;
      end
`ifdef IBUF_ERR_CHECK_EN
      if (bus.Pop_Valid && (bus.Pop_WarpID == 3'(w)) && (occ_q[w] == '0)) begin
        err_hit = 1'b1;
      end
`endif
      occ_d[w]  = occ_v;
      inf_d[w]  = inf_v;
      drop_d[w] = drop_v;
      wr_d[w]   = wr_v;
    end
  end

`ifdef IBUF_ERR_CHECK_EN
  always_comb begin
    err_d = err_q | err_hit;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        rd_q[w]   <= '0;
        wr_q[w]   <= '0;
        occ_q[w]  <= '0;
        inf_q[w]  <= '0;
        drop_q[w] <= '0;
      end
`ifdef IBUF_ERR_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      occ_q  <= occ_d;
      inf_q  <= inf_d;
      drop_q <= drop_d;
`ifdef IBUF_ERR_CHECK_EN
      err_q  <= err_d;
`endif
    end
  end

  // Storage needs no reset: Rd_Instr is gated by Head_Valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.REQ_IBuffer_PC   = req_vec;
  assign bus.Stall_IBuffer_PC = stall_vec;
  assign bus.Head_Valid       = hv_vec;
  assign bus.Rd_Instr         = hv_vec[bus.Rd_WarpID] ?
                                mem_q[bus.Rd_WarpID][rd_q[bus.Rd_WarpID]] : '0;
`ifdef IBUF_ERR_CHECK_EN
  assign bus.Err_IBuffer      = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibuffer_warp_queues.sv
`default_nettype none
// ============================================================================
// tb_ibuffer_warp_queues : directed vector table, corner sequences and a
// randomized run against a queue-based model. Revision 1.0
// ============================================================================
module tb_ibuffer_warp_queues;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  ibuffer_warp_queues_if #(.IW(32)) bus ();

  ibuffer_warp_queues #(.NUM_WARPS(8), .DEPTH(DEPTH), .IW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  grt;
    logic        v1;
    logic [2:0]  id1;
    logic [31:0] i1;
    logic        v2;
    logic [2:0]  id2;
    logic [31:0] i2;
    logic        pop;
    logic [2:0]  pid;
    logic [7:0]  flush;
    logic [2:0]  rdid;
    logic [7:0]  req;
    logic [7:0]  stall;
    logic [7:0]  hv;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [20];

  logic [31:0] mq   [8][$];
  int          minf [8];
  int          mdrop[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.GRT = '0;
    bus.Valid_ICache_1 = 1'b0; bus.WarpID_ICache_1 = '0; bus.Instr_ICache_1 = '0;
    bus.Valid_ICache_2 = 1'b0; bus.WarpID_ICache_2 = '0; bus.Instr_ICache_2 = '0;
    bus.Pop_Valid = 1'b0; bus.Pop_WarpID = '0;
    bus.Flush_Warp = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.GRT = v.grt;
    bus.Valid_ICache_1 = v.v1; bus.WarpID_ICache_1 = v.id1; bus.Instr_ICache_1 = v.i1;
    bus.Valid_ICache_2 = v.v2; bus.WarpID_ICache_2 = v.id2; bus.Instr_ICache_2 = v.i2;
    bus.Pop_Valid = v.pop; bus.Pop_WarpID = v.pid;
    bus.Flush_Warp = v.flush;
    bus.Rd_WarpID = v.rdid;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    chk("reset_req",   {24'h0, bus.REQ_IBuffer_PC},   32'hFF);
    chk("reset_stall", {24'h0, bus.Stall_IBuffer_PC}, 32'h00);
    chk("reset_hv",    {24'h0, bus.Head_Valid},       32'h00);
    chk("reset_rd",    bus.Rd_Instr,                  32'h0);
    rst_n = 1'b1;
    for (int w = 0; w < 8; w++) begin
      mq[w].delete();
      minf[w]  = 0;
      mdrop[w] = 0;
    end
  endtask

  // Reference: each warp is a queue of accepted instructions plus counts of
  // reserved and stale fetches.
  task automatic model_step();
    bit          req_pre [8];
    bit          v;
    logic [2:0]  id;
    logic [31:0] ins;
    for (int w = 0; w < 8; w++) req_pre[w] = (mq[w].size() + minf[w]) < DEPTH;
    for (int w = 0; w < 8; w++) begin
      int sz_pre = mq[w].size();
      for (int p = 0; p < 2; p++) begin
        v   = (p == 0) ? bus.Valid_ICache_1  : bus.Valid_ICache_2;
        id  = (p == 0) ? bus.WarpID_ICache_1 : bus.WarpID_ICache_2;
        ins = (p == 0) ? bus.Instr_ICache_1  : bus.Instr_ICache_2;
        if (v && (int'(id) == w)) begin
          if (mdrop[w] > 0) begin
            mdrop[w]--;
            minf[w]--;
          end else if (minf[w] > 0) begin
            minf[w]--;
            if (!bus.Flush_Warp[w]) mq[w].push_back(ins);
          end
        end
      end
      if (bus.GRT[w] && req_pre[w]) minf[w]++;
      if (bus.Flush_Warp[w]) begin
        mq[w].delete();
        mdrop[w] = minf[w];
      end else if (bus.Pop_Valid && (int'(bus.Pop_WarpID) == w) && (sz_pre > 0)) begin
        void'(mq[w].pop_front());
      end
    end
  endtask

  task automatic check_model();
    logic [7:0]  er, es, eh;
    logic [31:0] erd;
    for (int w = 0; w < 8; w++) begin
      er[w] = (mq[w].size() + minf[w]) <  DEPTH;
      es[w] = (mq[w].size() + minf[w]) == DEPTH;
      eh[w] = mq[w].size() != 0;
    end
    erd = (mq[bus.Rd_WarpID].size() != 0) ? mq[bus.Rd_WarpID][0] : 32'h0;
    chk("rand_req",   {24'h0, bus.REQ_IBuffer_PC},   {24'h0, er});
    chk("rand_stall", {24'h0, bus.Stall_IBuffer_PC}, {24'h0, es});
    chk("rand_hv",    {24'h0, bus.Head_Valid},       {24'h0, eh});
    chk("rand_rd",    bus.Rd_Instr,                  erd);
  endtask

  function automatic logic [2:0] pick_inflight();
    int s = $urandom_range(0, 7);
    if ($urandom_range(0, 3) != 0)
      for (int k = 0; k < 8; k++) if (minf[(s + k) % 8] > 0) return 3'((s + k) % 8);
    return 3'(s);
  endfunction

  function automatic logic [2:0] pick_full();
    int s = $urandom_range(0, 7);
    if ($urandom_range(0, 2) != 0)
      for (int k = 0; k < 8; k++) if (mq[(s + k) % 8].size() > 0) return 3'((s + k) % 8);
    return 3'(s);
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.Rd_WarpID = '0;
    //          grt   v1 id1   i1            v2 id2   i2            pop pid  flush rdid  req    stall  hv     rd
    tbl[0]  = '{8'h00,0,3'd0,32'h0,        0,3'd0,32'h0,        0,3'd0,8'h00,3'd0,8'hFF,8'h00,8'h00,32'h0};
    tbl[1]  = '{8'h05,0,3'd0,32'h0,        0,3'd0,32'h0,        0,3'd0,8'h00,3'd0,8'hFF,8'h00,8'h00,32'h0};
    tbl[2]  = '{8'h05,0,3'd0,32'h0,        0,3'd0,32'h0,        0,3'd0,8'h00,3'd0,8'hFA,8'h05,8'h00,32'h0};
    tbl[3]  = '{8'h00,1,3'd0,32'hAAAA0001, 1,3'd0,32'hAAAA0002, 0,3'd0,8'h00,3'd0,8'hFA,8'h05,8'h01,32'hAAAA0001};
    tbl[4]  = '{8'h00,0,3'd0,32'h0,        0,3'd0,32'h0,        1,3'd0,8'h00,3'd0,8'hFB,8'h04,8'h01,32'hAAAA0002};
    tbl[5]  = '{8'h00,0,3'd0,32'h0,        0,3'd0,32'h0,        1,3'd0,8'h00,3'd0,8'hFB,8'h04,8'h00,32'h0};
    tbl[6]  = '{8'h08,0,3'd0,32'h0,        0,3'd0,32'h0,        0,3'd0,8'h00,3'd0,8'hFB,8'h04,8'h00,32'h0};
    tbl[7]  = '{8'h08,0,3'd0,32'h0,        0,3'd0,32'h0,        0,3'd0,8'h00,3'd0,8'hF3,8'h0C,8'h00,32'h0};
    tbl[8]  = '{8'h00,1,3'd3,32'h33330001, 1,3'd3,32'h33330002, 0,3'd0,8'h00,3'd3,8'hF3,8'h0C,8'h08,32'h33330001};
    tbl[9]  = '{8'h08,0,3'd0,32'h0,        0,3'd0,32'h0,        1,3'd3,8'h00,3'd3,8'hFB,8'h04,8'h08,32'h33330002};
    tbl[10] = '{8'h20,0,3'd0,32'h0,        0,3'd0,32'h0,        0,3'd0,8'h00,3'd3,8'hFB,8'h04,8'h08,32'h33330002};
    tbl[11] = '{8'h20,1,3'd5,32'h55550001, 0,3'd0,32'h0,        0,3'd0,8'h00,3'd5,8'hDB,8'h24,8'h28,32'h55550001};
    tbl[12] = '{8'h00,0,3'd0,32'h0,        0,3'd0,32'h0,        0,3'd0,8'h20,3'd5,8'hFB,8'h04,8'h08,32'h0};
    tbl[13] = '{8'h00,0,3'd0,32'h0,        1,3'd5,32'hDEADBEEF, 0,3'd0,8'h00,3'd5,8'hFB,8'h04,8'h08,32'h0};
    tbl[14] = '{8'h00,1,3'd2,32'h22220001, 1,3'd2,32'h22220002, 0,3'd0,8'h00,3'd2,8'hFB,8'h04,8'h0C,32'h22220001};
    tbl[15] = '{8'h00,0,3'd0,32'h0,        0,3'd0,32'h0,        1,3'd2,8'h04,3'd2,8'hFF,8'h00,8'h08,32'h0};
    tbl[16] = '{8'h00,1,3'd1,32'h11110001, 0,3'd0,32'h0,        0,3'd0,8'h00,3'd1,8'hFF,8'h00,8'h08,32'h0};
    tbl[17] = '{8'h00,0,3'd0,32'h0,        0,3'd0,32'h0,        1,3'd3,8'h00,3'd3,8'hFF,8'h00,8'h00,32'h0};
    tbl[18] = '{8'h08,0,3'd0,32'h0,        0,3'd0,32'h0,        0,3'd0,8'h00,3'd3,8'hFF,8'h00,8'h00,32'h0};
    tbl[19] = '{8'h00,1,3'd3,32'h33330003, 0,3'd0,32'h0,        0,3'd0,8'h00,3'd3,8'hFF,8'h00,8'h08,32'h33330003};

    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i]);
      tick();
      chk($sformatf("vec%0d_req", i),   {24'h0, bus.REQ_IBuffer_PC},   {24'h0, tbl[i].req});
      chk($sformatf("vec%0d_stall", i), {24'h0, bus.Stall_IBuffer_PC}, {24'h0, tbl[i].stall});
      chk($sformatf("vec%0d_hv", i),    {24'h0, bus.Head_Valid},       {24'h0, tbl[i].hv});
      chk($sformatf("vec%0d_rd", i),    bus.Rd_Instr,                  tbl[i].rd);
    end

    // Flush in the same cycle as a return and a new grant on warp 4.
    idle_inputs();
    bus.Rd_WarpID = 3'd4;
    bus.GRT = 8'h10;
    tick();
    bus.GRT = 8'h10; bus.Flush_Warp = 8'h10;
    bus.Valid_ICache_1 = 1'b1; bus.WarpID_ICache_1 = 3'd4; bus.Instr_ICache_1 = 32'h44440000;
    tick();
    chk("fl4_hv",  {31'h0, bus.Head_Valid[4]},     32'h0);
    chk("fl4_req", {31'h0, bus.REQ_IBuffer_PC[4]}, 32'h1);
    idle_inputs();
    bus.Valid_ICache_2 = 1'b1; bus.WarpID_ICache_2 = 3'd4; bus.Instr_ICache_2 = 32'hDEAD0004;
    tick();
    chk("fl4_drop_hv", {31'h0, bus.Head_Valid[4]}, 32'h0);
    chk("fl4_drop_rd", bus.Rd_Instr,               32'h0);
    idle_inputs();
    bus.GRT = 8'h10;
    tick();
    idle_inputs();
    bus.Valid_ICache_2 = 1'b1; bus.WarpID_ICache_2 = 3'd4; bus.Instr_ICache_2 = 32'h44440001;
    tick();
    chk("fl4_new_hv",    {31'h0, bus.Head_Valid[4]},       32'h1);
    chk("fl4_new_rd",    bus.Rd_Instr,                     32'h44440001);
    chk("fl4_new_stall", {31'h0, bus.Stall_IBuffer_PC[4]}, 32'h0);

    // Randomized run against the queue model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      if ($urandom_range(0, 3) != 0) bus.GRT[$urandom_range(0, 7)] = 1'b1;
      if ($urandom_range(0, 2) == 0) bus.GRT[$urandom_range(0, 7)] = 1'b1;
      bus.Valid_ICache_1 = 1'($urandom_range(0, 1));
      bus.WarpID_ICache_1 = pick_inflight();
      bus.Instr_ICache_1 = $urandom;
      bus.Valid_ICache_2 = 1'($urandom_range(0, 1));
      bus.WarpID_ICache_2 = pick_inflight();
      bus.Instr_ICache_2 = $urandom;
      bus.Pop_Valid = 1'($urandom_range(0, 1));
      bus.Pop_WarpID = pick_full();
      if ($urandom_range(0, 15) == 0) bus.Flush_Warp[$urandom_range(0, 7)] = 1'b1;
      bus.Rd_WarpID = 3'($urandom_range(0, 7));
      model_step();
      tick();
      check_model();
    end

`ifdef IBUF_ERR_CHECK_EN
    do_reset();
    chk("err_reset", {31'h0, bus.Err_IBuffer}, 32'h0);
    idle_inputs();
    bus.Pop_Valid = 1'b1; bus.Pop_WarpID = 3'd7;
    tick();
    chk("err_set", {31'h0, bus.Err_IBuffer}, 32'h1);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("err_hold", {31'h0, bus.Err_IBuffer}, 32'h1);
    end
    do_reset();
    chk("err_clear", {31'h0, bus.Err_IBuffer}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
